spi_ram_slave_burst: RTL
========================

// Module: spi_ram_slave_burst
// PURPOSE
//  Parametrised SPI-slave-to-RAM bridge, successor of the fixed 8-bit/256-word
//  SPI slave. Frame = 2-bit opcode + payload, MSB first. Address/data widths and
//  depth are generic; optional auto-increment burst reads/writes per SS_n frame.
//  Sits behind the board SPI pins as a register/scratch memory.
// PARAMETERS
//  ADDR_WIDTH  8    address payload bits; pointer width
//  DATA_WIDTH  8    word/data payload bits (>=2)
//  MEM_DEPTH   256  words; need not be 2**ADDR_WIDTH (<= 2**ADDR_WIDTH)
// PORTS
//  clk          in   1  single clock; MOSI/SS_n sampled, MISO driven on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  SS_n         in   1  slave select, active low; low = frame in progress
//  MOSI         in   1  serial in, MSB first
//  MISO         out  1  serial out, MSB first; 0 when not shifting read data
//  frame_abort  out  1  1-cycle pulse: SS_n rose before current payload completed
// BEHAVIOUR
//  Reset (async): state IDLE, wr_ptr=rd_ptr=0, MISO=0, frame_abort=0, bit count 0.
//   RAM contents not reset.
//  States: IDLE, OPC, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA.
//  IDLE: first posedge with SS_n=0 samples opcode bit1 -> OPC; next edge samples
//   bit0 and branches: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
//  WR_ADDR/RD_ADDR: shift ADDR_WIDTH bits; on last bit load wr_ptr/rd_ptr.
//   Further bits in the frame ignored.
//  WR_DATA: shift DATA_WIDTH bits; last bit sampled at edge W -> RAM written
//   mem[wr_ptr] at edge W+1 (commits even if SS_n rises at W+1).
//  RD_DATA: opcode bit0 sampled at edge E; RAM read of rd_ptr registered at
//   E+1; shift reg loaded at E+2; MISO=bit DATA_WIDTH-1 after E+2, next bit
//   after each subsequent edge; LSB after E+1+DATA_WIDTH. MOSI ignored.
//  SS_n high has priority over everything: next edge -> IDLE, MISO=0, partial
//   address/data discarded (no RAM write, pointer unchanged); frame_abort=1 for
//   that one cycle iff a payload was partially shifted (incl. mid-OPC).
//   SS_n high after a complete payload: no abort pulse.
//  Address range: pointer increment wraps MEM_DEPTH-1 -> 0. Out-of-range
//   pointer (>=MEM_DEPTH): write dropped, read returns all-zero word; increment
//   from out-of-range also goes to 0.
//  MISO is 0 in every state except RD_DATA shift phase.
// CONFIGURATION
//  SPI_RAM_AUTOINC_EN defined: after each completed WR_DATA word wr_ptr
//   increments (at W+1) and shifting continues for the next word in the same
//   frame; in RD_DATA rd_ptr increments at each load and next word is
//   prefetched so its MSB follows previous LSB with no gap cycle.
//  Not defined: one word per frame; pointers never auto-increment; extra MOSI
//   bits ignored, MISO=0 after the LSB until SS_n rises.
// STRUCTURE
//  spi_ram_pkg.vh: opcode localparams (OPC_WR_ADDR..OPC_RD_DATA), state
//   encodings, CNT_WIDTH = clog2(max(ADDR_WIDTH,DATA_WIDTH)+1).
//  Sub-module spi_ram_sp: single-port sync RAM (MEM_DEPTH x DATA_WIDTH,
//   1-cycle registered read, range check here). FSM/shift/pointers in top.
// TESTING (ADDR_WIDTH=8, DATA_WIDTH=8, MEM_DEPTH=256 unless noted)
//  1. WR_ADDR 0x01, WR_DATA 0x8A, RD_ADDR 0x01, RD_DATA -> MISO 0x8A MSB first
//     starting 2 cycles after opcode, frame_abort never pulses.
//  2. AUTOINC_EN: WR_ADDR 0xFE, one WR_DATA frame 0x11,0x22,0x33 -> mem[FE]=11,
//     mem[FF]=22, mem[00]=33; RD_ADDR 0xFE, 24-bit RD_DATA -> 112233 gapless.
//  3. WR_DATA frame, SS_n rises after 5 data bits -> frame_abort 1 cycle,
//     mem[wr_ptr] unchanged, wr_ptr unchanged, MISO 0.
//  4. rst_n low mid RD_DATA bit 3 -> MISO 0 same cycle, IDLE, pointers 0;
//     subsequent RD_DATA reads mem[0].
//  5. Macro off: WR_ADDR 0x01, 16-bit WR_DATA 0xA55A -> mem[01]=0xA5,
//     mem[02] untouched, wr_ptr stays 0x01.
//  6. MEM_DEPTH=200: WR_ADDR 0xF0, WR_DATA 0x7E dropped; RD_ADDR 0xF0 ->
//     MISO 0x00; with AUTOINC burst next word read from address 0.

Source files
------------

// File: rtl/spi_ram_slave_burst_pkg.sv
// Shared definitions for the SPI-to-RAM bridge: opcode values, FSM state
// encoding and width helpers used to size the bit counter and shift register.
package spi_ram_slave_burst_pkg;

  localparam logic [1:0] OPC_WR_ADDR = 2'b00;
  localparam logic [1:0] OPC_WR_DATA = 2'b01;
  localparam logic [1:0] OPC_RD_ADDR = 2'b10;
  localparam logic [1:0] OPC_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StOpc,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdData
  } state_e;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter must reach the full payload length, hence the +1.
  function automatic int unsigned cnt_width(int unsigned aw, int unsigned dw);
    return $clog2(max_u(aw, dw) + 1);
  endfunction

endpackage

// File: rtl/spi_ram_slave_burst_sp.sv
// Single-port synchronous RAM, MEM_DEPTH x DATA_WIDTH, one-cycle registered
// read. Addresses at or beyond MEM_DEPTH drop writes and read back zero.
// Ports:
//   clk      clock
//   we_i     write enable
//   addr_i   word address (ADDR_WIDTH bits, may exceed MEM_DEPTH-1)
//   wdata_i  write data
//   rdata_o  registered read data of addr_i (zero when out of range)
module spi_ram_slave_burst_sp #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned PW   = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] Depth = PW'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  in_range;
  logic [IdxW-1:0]       idx;

  assign in_range = {1'b0, addr_i} < Depth;
  assign idx      = IdxW'(addr_i);

  always_ff @(posedge clk) begin
    if (we_i && in_range) begin
      mem_q[idx] <= wdata_i;
    end
    rdata_o <= in_range ? mem_q[idx] : '0;
  end

endmodule

// File: rtl/spi_ram_slave_burst.sv
// SPI slave bridging a 2-bit-opcode serial protocol onto a scratch RAM.
// Frame: opcode (00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data) then
// payload, MSB first, while SS_n is low. SS_n high always returns to idle.
// Build option: define SPI_RAM_AUTOINC_EN for auto-incrementing burst
// reads/writes within one frame; otherwise one word per frame.
// Ports:
//   clk          clock; MOSI/SS_n sampled and MISO driven on posedge
//   rst_n        asynchronous active-low reset
//   SS_n         slave select, active low
//   MOSI         serial data in
//   MISO         serial data out, 0 unless shifting read data
//   frame_abort  one-cycle pulse when SS_n rises mid-payload
module spi_ram_slave_burst
  import spi_ram_slave_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_abort
);

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  localparam int unsigned SrW       = max_u(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_WIDTH = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned PW        = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] AddrLast  = CNT_WIDTH'(ADDR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] DataLast  = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] DataFull  = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [PW-1:0]        DepthLast = PW'(MEM_DEPTH - 1);

  state_e                 state_q;
  logic                   opc_hi_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   done_q;     // current payload complete, SS_n may rise
  logic                   rd_wait_q;  // one edge for the RAM read to register
  logic [SrW-1:0]         sr_q;
  logic [SrW-1:0]         sr_next;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q;
  logic                   wr_pend_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  // Wraps at the last valid word; out-of-range pointers also restart at 0.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(logic [ADDR_WIDTH-1:0] p);
    if ({1'b0, p} >= DepthLast) begin
      return '0;
    end
    return p + ADDR_WIDTH'(1);
  endfunction

  assign sr_next  = {sr_q[SrW-2:0], MOSI};
  // Single port: a pending write owns the address for its one cycle.
  assign ram_addr = wr_pend_q ? wr_ptr_q : rd_ptr_q;

  spi_ram_slave_burst_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_pend_q),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opc_hi_q    <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rd_wait_q   <= 1'b0;
      sr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_pend_q   <= 1'b0;
      wdata_q     <= '0;
      MISO        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      wr_pend_q   <= 1'b0;
      frame_abort <= 1'b0;
      // The write launched by the last data bit commits regardless of SS_n.
      if (wr_pend_q && AutoInc) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (SS_n) begin
        frame_abort <= (state_q != StIdle) && !done_q;
        state_q     <= StIdle;
        MISO        <= 1'b0;
        cnt_q       <= '0;
        done_q      <= 1'b0;
        rd_wait_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            opc_hi_q <= MOSI;
            state_q  <= StOpc;
          end
          StOpc: begin
            cnt_q     <= '0;
            done_q    <= 1'b0;
            rd_wait_q <= 1'b1;
            unique case ({opc_hi_q, MOSI})
              OPC_WR_ADDR: state_q <= StWrAddr;
              OPC_WR_DATA: state_q <= StWrData;
              OPC_RD_ADDR: state_q <= StRdAddr;
              OPC_RD_DATA: state_q <= StRdData;
            endcase
          end
          StWrAddr, StRdAddr: begin
            if (!done_q) begin
              sr_q <= sr_next;
              if (cnt_q == AddrLast) begin
                done_q <= 1'b1;
                if (state_q == StWrAddr) begin
                  wr_ptr_q <= sr_next[ADDR_WIDTH-1:0];
                end else begin
                  rd_ptr_q <= sr_next[ADDR_WIDTH-1:0];
                end
              end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
              end
            end
          end
          StWrData: begin
            // Without auto-increment, bits after the first word are ignored.
            if (!done_q || AutoInc) begin
              sr_q   <= sr_next;
              done_q <= 1'b0;
              cnt_q  <= cnt_q + CNT_WIDTH'(1);
              if (cnt_q == DataLast) begin
                wdata_q   <= sr_next[DATA_WIDTH-1:0];
                wr_pend_q <= 1'b1;
                cnt_q     <= '0;
                done_q    <= 1'b1;
              end
            end
          end
          StRdData: begin
            if (rd_wait_q) begin
              rd_wait_q <= 1'b0;
            end else if (cnt_q == '0 || (AutoInc && cnt_q == DataFull)) begin
              // Load: MSB out now, the rest queued in the shift register.
              MISO   <= ram_rdata[DATA_WIDTH-1];
              sr_q   <= SrW'({ram_rdata[DATA_WIDTH-2:0], 1'b0});
              cnt_q  <= CNT_WIDTH'(1);
              done_q <= 1'b0;
              if (AutoInc) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
              end
            end else if (cnt_q == DataFull) begin
              MISO <= 1'b0;
            end else begin
              MISO  <= sr_q[DATA_WIDTH-1];
              sr_q  <= {sr_q[SrW-2:0], 1'b0};
              cnt_q <= cnt_q + CNT_WIDTH'(1);
              if (cnt_q == DataLast) begin
                done_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
